// File: rtl/l2_wb_pkg.sv
// Shared types and default widths for the L2 posted-write buffer.
package l2_wb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    WR_MEM = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/l2_write_buffer_store.sv
// Circular entry store for the write buffer: push at tail, pop at head,
// in-place data overwrite, and a combinational address lookup.
module wb_store
  import l2_wb_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              cw_en,
  input  logic [IDX_W-1:0]  cw_idx,
  input  logic [DATA_W-1:0] cw_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              match,
  output logic [IDX_W-1:0]  match_idx,
  output logic [DATA_W-1:0] match_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count_nxt,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

  // Control state: valid bits, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_nxt;
    end
  end

  // Payload storage; only meaningful where valid_q is set
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
    if (cw_en) begin
      data_q[cw_idx] <= cw_data;
    end
  end

  // Coalescing guarantees at most one valid entry per address
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  assign match_data = data_q[match_idx];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/l2_write_buffer.sv
// Posted-write buffer between the L2 memory port and main memory: absorbs
// write-backs, forwards buffered data to reads, drains when memory is idle.
module l2_write_buffer
  import l2_wb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic [DATA_W-1:0] l2_wdata,
  output logic [DATA_W-1:0] l2_rdata,
  output logic              l2_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_state_e         state_q;
  wb_state_e         state_nxt;
  logic              do_push;
  logic              do_pop;
  logic              do_cw;
  logic              rd_hit;
  logic              rd_miss;
  logic              rd_done;
  logic              start_drain;
  logic              match;
  logic [IDX_W-1:0]  match_idx;
  logic [DATA_W-1:0] match_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count_nxt;
  logic              full;
  logic              empty;

  wb_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .push        (do_push),
    .push_addr   (l2_addr),
    .push_data   (l2_wdata),
    .pop         (do_pop),
    .cw_en       (do_cw),
    .cw_idx      (match_idx),
    .cw_data     (l2_wdata),
    .lookup_addr (l2_addr),
    .match       (match),
    .match_idx   (match_idx),
    .match_data  (match_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count_nxt   (count_nxt),
    .full        (full),
    .empty       (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Reads outrank writes; a full buffer with a new address forces a drain first
  always_comb begin
    state_nxt   = state_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    do_cw       = 1'b0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    rd_done     = 1'b0;
    start_drain = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (l2_read) begin
          if (match) begin
            rd_hit    = 1'b1;
            state_nxt = RESP;
          end else begin
            rd_miss   = 1'b1;
            state_nxt = RD_MEM;
          end
        end else if (l2_write) begin
          if (match) begin
            do_cw     = 1'b1;
            state_nxt = RESP;
          end else if (!full) begin
            do_push   = 1'b1;
            state_nxt = RESP;
          end else begin
            start_drain = 1'b1;
            state_nxt   = WR_MEM;
          end
        end else if (!empty) begin
          start_drain = 1'b1;
          state_nxt   = WR_MEM;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          rd_done   = 1'b1;
          state_nxt = RESP;
        end
      end
      WR_MEM: begin
        if (mem_ready) begin
          do_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; head entry is stable for the whole drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2_ready  <= 1'b0;
      l2_rdata  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_empty  <= 1'b1;
    end else begin
      l2_ready <= (state_nxt == RESP);
      if (rd_hit)       l2_rdata <= match_data;
      else if (rd_done) l2_rdata <= mem_rdata;
      if (rd_miss) begin
        mem_read <= 1'b1;
        mem_addr <= l2_addr;
      end else if (rd_done) begin
        mem_read <= 1'b0;
      end
      if (start_drain) begin
        mem_write <= 1'b1;
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end else if (do_pop) begin
        mem_write <= 1'b0;
      end
      wb_empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed self-checking bench for l2_write_buffer.
module tb_l2_write_buffer;

  localparam int AW = 28;
  localparam int DW = 128;

  localparam logic [DW-1:0] DA = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
  localparam logic [DW-1:0] DB = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004};
  localparam logic [DW-1:0] DC = {32'hCCCC_0001, 32'hCCCC_0002, 32'hCCCC_0003, 32'hCCCC_0004};
  localparam logic [DW-1:0] DD = {32'hDDDD_0001, 32'hDDDD_0002, 32'hDDDD_0003, 32'hDDDD_0004};

  logic          clk;
  logic          reset;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata;
  logic [DW-1:0] l2_rdata;
  logic          l2_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          wb_empty;

  int checks = 0;
  int errors = 0;
  int seen;

  l2_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_ready  (l2_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .wb_empty  (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] fill_data(input int i);
    return {4{32'hF00D_0000 + 32'(i)}};
  endfunction

  // Waits (bounded) for a drain, checks its payload, completes it with one mem_ready pulse
  task automatic drain_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int k = 0; k < 10 && !mem_write; k++) tick();
    chk("drain_start", mem_write, 1);
    chk("drain_addr", mem_addr, a);
    chk("drain_data", mem_wdata, d);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("drain_end", mem_write, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; l2_read = 1'b0; l2_write = 1'b0; l2_addr = '0; l2_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) tick();
    chk("rst_l2_ready", l2_ready, 0);
    chk("rst_l2_rdata", l2_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_wb_empty", wb_empty, 1);
    reset = 1'b1;
    tick();

    // Single write, then drain when L2 goes idle
    l2_write = 1'b1; l2_addr = 28'h0000010; l2_wdata = DA;
    tick();
    chk("wr_ready", l2_ready, 1);
    chk("wr_nonempty", wb_empty, 0);
    l2_write = 1'b0;
    tick();
    chk("ready_pulse", l2_ready, 0);
    drain_one(28'h0000010, DA);
    chk("drained_empty", wb_empty, 1);

    // Fill to DEPTH back-to-back so no drain can start
    l2_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      l2_addr = AW'(i); l2_wdata = fill_data(i);
      tick();
      chk("fill_ready", l2_ready, 1);
      tick();
    end
    l2_addr = 28'h5; l2_wdata = fill_data(5);
    chk("full_count", dut.u_store.count_q, 4);
    tick();
    chk("full_drain_start", mem_write, 1);
    chk("full_drain_addr", mem_addr, 28'h1);
    chk("full_drain_data", mem_wdata, fill_data(1));
    chk("full_stall", l2_ready, 0);
    repeat (2) tick();
    chk("full_stall_hold", mem_write, 1);
    chk("full_stall_ready", l2_ready, 0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("full_drain_end", mem_write, 0);
    chk("full_no_ready_yet", l2_ready, 0);
    tick();
    chk("fifth_ready", l2_ready, 1);
    chk("fifth_count", dut.u_store.count_q, 4);
    l2_write = 1'b0;
    for (int i = 2; i <= 5; i++) drain_one(AW'(i), fill_data(i));
    chk("fill_empty", wb_empty, 1);

    // Read hit served from the buffer
    l2_write = 1'b1; l2_addr = 28'h20; l2_wdata = DA;
    tick();
    chk("hit_wr_ready", l2_ready, 1);
    l2_write = 1'b0; l2_read = 1'b1;
    tick();
    tick();
    chk("hit_ready", l2_ready, 1);
    chk("hit_rdata", l2_rdata, DA);
    chk("hit_no_mem_read", mem_read, 0);

    // Coalesce into the same entry
    l2_read = 1'b0; l2_write = 1'b1; l2_wdata = DB;
    tick();
    chk("hit_no_mem_read2", mem_read, 0);
    tick();
    chk("co_ready", l2_ready, 1);
    chk("co_count", dut.u_store.count_q, 1);
    l2_write = 1'b0;
    drain_one(28'h20, DB);
    seen = 0;
    repeat (4) begin
      tick();
      if (mem_write) seen++;
    end
    chk("co_single_write", seen, 0);
    chk("co_empty", wb_empty, 1);

    // Read miss goes to memory
    l2_read = 1'b1; l2_addr = 28'h30;
    tick();
    chk("miss_mem_read", mem_read, 1);
    chk("miss_mem_addr", mem_addr, 28'h30);
    chk("miss_no_ready", l2_ready, 0);
    tick();
    chk("miss_hold", mem_read, 1);
    mem_rdata = DC; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("miss_ready", l2_ready, 1);
    chk("miss_rdata", l2_rdata, DC);
    chk("miss_read_drop", mem_read, 0);
    l2_read = 1'b0;
    tick();
    chk("miss_ready_pulse", l2_ready, 0);

    // Read and write together: read wins, write is dropped
    l2_read = 1'b1; l2_write = 1'b1; l2_addr = 28'h40; l2_wdata = DA;
    tick();
    chk("rw_mem_read", mem_read, 1);
    chk("rw_no_mem_write", mem_write, 0);
    mem_rdata = DB; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("rw_ready", l2_ready, 1);
    chk("rw_rdata", l2_rdata, DB);
    l2_read = 1'b0; l2_write = 1'b0;
    repeat (2) tick();
    chk("rw_write_ignored", wb_empty, 1);
    chk("rw_no_drain", mem_write, 0);

    // Asynchronous reset during a drain discards the entry
    l2_write = 1'b1; l2_addr = 28'h50; l2_wdata = DD;
    tick();
    chk("rst_wr_ready", l2_ready, 1);
    l2_write = 1'b0;
    for (int k = 0; k < 10 && !mem_write; k++) tick();
    chk("rst_drain_start", mem_write, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_l2_ready", l2_ready, 0);
    chk("arst_l2_rdata", l2_rdata, 0);
    chk("arst_mem_read", mem_read, 0);
    chk("arst_mem_write", mem_write, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_wb_empty", wb_empty, 1);
    #2 reset = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (mem_write) seen++;
    end
    chk("arst_entry_discarded", seen, 0);
    chk("arst_still_empty", wb_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

Posted-write buffer between the L2 cache's memory port and main memory. Absorbs L2 dirty-block write-backs into a small FIFO so L2 refills can reach memory without waiting behind them. Drains the FIFO to memory when the memory port is otherwise idle. Read requests are served from the buffer when their address matches a buffered block, so memory is never read stale.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2.
- ADDR_W, 28: block address width.
- DATA_W, 128: block data width (4 words).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- l2_read  in  1  L2 read request; held until l2_ready.
- l2_write  in  1  L2 write-back request; held until l2_ready.
- l2_addr  in  ADDR_W  block address.
- l2_wdata  in  DATA_W  write-back data.
- l2_rdata  out  DATA_W  read data; valid while l2_ready=1.
- l2_ready  out  1  one-cycle completion pulse to L2.
- mem_read  out  1  memory read request; held until mem_ready.
- mem_write  out  1  memory write request; held until mem_ready.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion pulse.
- wb_empty  out  1  buffer holds no entries.

## Operation
- Each entry holds valid, address and data. Head/tail pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- FSM states:
  - IDLE: no memory transaction open.
  - RD_MEM: memory read open.
  - WR_MEM: draining the head entry to memory.
  - RESP: l2_ready high for one cycle.
- IDLE priority, highest first:
  - l2_read: if any valid entry address equals l2_addr, load that entry's data into l2_rdata and go RESP. Otherwise register mem_read=1 and mem_addr=l2_addr, and go RD_MEM.
  - l2_write with address match: overwrite that entry's data in place (coalesce), count unchanged, go RESP. Coalescing applies even when full.
  - l2_write, no match, count<DEPTH: push at tail, count+1, go RESP.
  - l2_write, no match, full: start draining the head (WR_MEM). The write is accepted after the drain returns to IDLE.
  - No request, count>0: start draining the head (WR_MEM).
- RD_MEM: on mem_ready, capture mem_rdata into l2_rdata, drop mem_read, go RESP.
- WR_MEM: mem_write=1, mem_addr and mem_wdata taken from the head entry. On mem_ready: pop head, count−1, drop mem_write, go IDLE. An in-progress drain always completes before any L2 request is serviced.
- RESP: l2_ready=1 and go IDLE. L2 request inputs are ignored in this cycle, because L2's request registers are still high.
- l2_read and l2_write both high is illegal. The read is served and the write is ignored.
- At most one entry can match any address, because coalescing prevents duplicates.

## Timing
- Reset values: l2_ready=0, l2_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wb_empty=1. After reset: state IDLE, count=0, all entries invalid.
- Reset asserted mid-transaction aborts it and discards buffered data.
- All outputs are registered. wb_empty is registered and equals (count==0).
- Write accept (push or coalesce) and read hit: request sampled in cycle N, l2_ready=1 in N+1. Buffer state is updated at the end of cycle N.
- Read miss: request sampled in N, mem_read=1 from N+1. mem_ready in cycle M gives l2_ready plus data in M+1, and mem_read=0 in M+1.
- Drain: mem_write rises one cycle after the decision and falls the cycle after mem_ready. The pop is visible at the end of the mem_ready cycle.
- Minimum idle gap between two memory requests: one cycle.

## Structure
- Package l2_wb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State enum: IDLE, RD_MEM, WR_MEM, RESP.
  - Entry struct: valid, addr, data.
- Sub-module wb_store holds the storage array, head/tail pointers and count, with push, pop and coalesce-write ports. It provides a combinational match/index/data lookup on an address.
- The top level holds the FSM and the output registers.

## Test plan
- Write 0x0000010 with data A: l2_ready one cycle after the request. Then, with L2 idle, mem_write appears with addr 0x0000010 and data A. On mem_ready, wb_empty=1.
- Fill 4 writes, addresses 0x1–0x4, while holding mem_ready low. A 5th write to 0x5 stalls, and mem_write starts for 0x1. Pulse mem_ready: 0x5 is then accepted with l2_ready, and count=4.
- Write 0x20 with data A, then read 0x20 before any drain: l2_rdata=A one cycle after the request, and no mem_read is issued.
- Write 0x20 with data A, then write 0x20 with data B (coalesce): only one memory write is issued, with data B, and count peaks at 1.
- Read 0x30 with an empty buffer: mem_read with addr 0x30. mem_ready with mem_rdata=C gives l2_rdata=C and l2_ready exactly one cycle later.
- Reset asserted while mem_write is high: all outputs return to 0 asynchronously and wb_empty=1. The previously buffered entry is never written to memory.
